vector_accumulate_unit: RTL and testbench

- Stage directly downstream of the filter reduce unit. Consumes its per-vector histograms and counts, and accumulates them element-wise per chain across a frame.
- A frame runs from bof[0] to eof[0]. One accumulated vector is emitted per frame at eof[0].
- Per-chain firmware selects one of three modes: pass-through, sum, or max.
- Reconfigured over the shared configId/configData byte bus while tracing is low.

---
 rtl/lebug_vau_pkg.sv | 9 +
 rtl/vau_lane.sv | 11 +
 rtl/vector_accumulate_unit.sv | 100 ++++++++++
 tb/tb_vector_accumulate_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/lebug_vau_pkg.sv
// lebug_vau_pkg: op codes and chain-id width helper shared by the reduce and accumulate stages
package lebug_vau_pkg;
    localparam logic [7:0] OP_PASS = 8'd0;
    localparam logic [7:0] OP_SUM  = 8'd1;
    localparam logic [7:0] OP_MAX  = 8'd2;
    function automatic int vau_width_chain(input int max_chains);
        return (max_chains > 1) ? $clog2(max_chains) : 1;
    endfunction
endpackage

// File: rtl/vau_lane.sv
// vau_lane: combines one accumulator lane with the incoming element according to the op
module vau_lane import lebug_vau_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [7:0]            op_i,
    input  logic [DATA_WIDTH-1:0] base_i,
    input  logic [DATA_WIDTH-1:0] vec_i,
    output logic [DATA_WIDTH-1:0] new_o
);
    always_comb new_o = op_i == OP_SUM ? base_i + vec_i : op_i == OP_MAX ? (base_i > vec_i ? base_i : vec_i) : vec_i;
endmodule

// File: rtl/vector_accumulate_unit.sv
// vector_accumulate_unit: per-chain frame accumulation (pass/sum/max) of upstream vectors, latency 2
module vector_accumulate_unit import lebug_vau_pkg::*; #(
    parameter int                         N                   = 8,
    parameter int                         DATA_WIDTH          = 32,
    parameter int                         MAX_CHAINS          = 4,
    parameter logic [7:0]                 PERSONAL_CONFIG_ID  = 8'd1,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_OP = '0,
    localparam int                        CW                  = vau_width_chain(MAX_CHAINS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tracing,
    input  logic                             valid_in,
    input  logic [1:0]                       eof_in,
    input  logic [1:0]                       bof_in,
    input  logic [CW-1:0]                    chainId_in,
    input  logic [7:0]                       configId,
    input  logic [7:0]                       configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
    output logic [CW-1:0]                    chainId_out,
    output logic                             valid_out,
    output logic [1:0]                       eof_out,
    output logic [1:0]                       bof_out
);
    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
    logic                       valid_s1_q;
    vec_t                       vec_s1_q;
    logic [CW-1:0]              chain_s1_q;
    logic [1:0]                 eof_s1_q, bof_s1_q;
    logic [7:0]                 op_s1_q, op_s1_d;
    vec_t [MAX_CHAINS-1:0]      acc_q, acc_d;
    logic [MAX_CHAINS-1:0][7:0] fw_q, fw_d;
    logic [7:0]                 cnt_q, cnt_d;
    vec_t                       base, new_vec, vec_out_d;
    logic                       valid_out_d, acc_op;
    // Unknown op codes collapse to PASS here so S2 only ever sees the three real ops.
    always_comb op_s1_d = (fw_q[chainId_in] == OP_SUM || fw_q[chainId_in] == OP_MAX) ? fw_q[chainId_in] : OP_PASS;
    always_comb acc_op = op_s1_q != OP_PASS;
    always_comb base = bof_s1_q[0] ? '0 : acc_q[chain_s1_q];
    for (genvar g = 0; g < N; g++) begin : g_lane
        vau_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .op_i  (op_s1_q),
            .base_i(base[g]),
            .vec_i (vec_s1_q[g]),
            .new_o (new_vec[g])
        );
    end
    always_comb begin
        acc_d       = acc_q;
        valid_out_d = 1'b0;
        if (!tracing) acc_d = '0;
        else if (valid_s1_q) begin
            valid_out_d = !acc_op || eof_s1_q[0];
            if (acc_op) acc_d[chain_s1_q] = eof_s1_q[0] ? '0 : new_vec;
        end
        vec_out_d = valid_out_d ? new_vec : vector_out;
    end
    always_comb begin
        fw_d  = fw_q;
        cnt_d = '0;
        if (!tracing && configId == PERSONAL_CONFIG_ID) begin
            cnt_d = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
            if (32'(cnt_q) < MAX_CHAINS) fw_d[cnt_q[CW-1:0]] = configData;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_q  <= 1'b0;
            vec_s1_q    <= '0;
            chain_s1_q  <= '0;
            eof_s1_q    <= '0;
            bof_s1_q    <= '0;
            op_s1_q     <= OP_PASS;
            acc_q       <= '0;
            fw_q        <= INITIAL_FIRMWARE_OP;
            cnt_q       <= '0;
            vector_out  <= '0;
            valid_out   <= 1'b0;
            chainId_out <= '0;
            eof_out     <= '0;
            bof_out     <= '0;
        end else begin
            valid_s1_q  <= valid_in && tracing;
            vec_s1_q    <= vector_in;
            chain_s1_q  <= chainId_in;
            eof_s1_q    <= eof_in;
            bof_s1_q    <= bof_in;
            op_s1_q     <= op_s1_d;
            acc_q       <= acc_d;
            fw_q        <= fw_d;
            cnt_q       <= cnt_d;
            vector_out  <= vec_out_d;
            valid_out   <= valid_out_d;
            chainId_out <= chain_s1_q;
            eof_out     <= eof_s1_q;
            bof_out     <= bof_s1_q;
        end
    end
endmodule

// File: tb/tb_vector_accumulate_unit.sv
// tb_vector_accumulate_unit: directed checks of pass/sum/max accumulation, config and reset
module tb_vector_accumulate_unit;
    logic            clk = 1'b0, rst_n = 1'b0, tracing = 1'b0, valid_in = 1'b0;
    logic [1:0]      eof_in = '0, bof_in = '0, chainId_in = '0;
    logic [7:0]      configId = '0, configData = '0;
    logic [7:0][31:0] vector_in = '0;
    logic [7:0][31:0] vector_out;
    logic [1:0]      chainId_out, eof_out, bof_out;
    logic            valid_out;
    int              checks = 0, passed = 0;

    always #5 clk = ~clk;

    vector_accumulate_unit dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
        .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
        .configId(configId), .configData(configData), .vector_in(vector_in),
        .vector_out(vector_out), .chainId_out(chainId_out), .valid_out(valid_out),
        .eof_out(eof_out), .bof_out(bof_out)
    );

    function automatic logic [255:0] splat(input logic [31:0] v);
        return {8{v}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [1:0] c, input logic b, input logic e, input logic [255:0] v);
        valid_in = 1'b1; chainId_in = c; bof_in = {1'b0, b}; eof_in = {1'b0, e}; vector_in = v;
        cyc();
        valid_in = 1'b0; bof_in = '0; eof_in = '0;
    endtask

    task automatic config4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        tracing = 1'b0; configId = 8'd1;
        configData = b0; cyc();
        configData = b1; cyc();
        configData = b2; cyc();
        configData = b3; cyc();
        chk("cfg_valid_low", 256'(valid_out), 256'd0);
        configId = 8'd0; tracing = 1'b1;
    endtask

    initial begin
        #12;
        chk("rst_vec", 256'(vector_out), 256'd0);
        chk("rst_valid", 256'(valid_out), 256'd0);
        chk("rst_chain", 256'(chainId_out), 256'd0);
        chk("rst_eof_bof", 256'({eof_out, bof_out}), 256'd0);
        rst_n = 1'b1;
        // chain0 SUM, chain1 MAX, chain2 SUM, chain3 PASS
        config4(8'd1, 8'd2, 8'd1, 8'd0);

        send(2'd0, 1'b1, 1'b0, splat(32'd5));
        send(2'd0, 1'b0, 1'b0, splat(32'd7));
        chk("sum_bof_out", 256'(bof_out), 256'd1);
        chk("sum_mid_valid", 256'(valid_out), 256'd0);
        send(2'd0, 1'b0, 1'b1, splat(32'd9));
        chk("sum_mid_valid2", 256'(valid_out), 256'd0);
        cyc();
        chk("sum_valid", 256'(valid_out), 256'd1);
        chk("sum_vec", 256'(vector_out), splat(32'd21));
        chk("sum_chain", 256'(chainId_out), 256'd0);
        chk("sum_eof_out", 256'(eof_out), 256'd1);
        cyc();
        chk("sum_valid_drop", 256'(valid_out), 256'd0);

        send(2'd1, 1'b1, 1'b0, 256'd3);
        send(2'd1, 1'b0, 1'b0, 256'd10);
        send(2'd1, 1'b0, 1'b1, 256'd4);
        cyc();
        chk("max_vec", 256'(vector_out), 256'd10);
        chk("max_chain", 256'(chainId_out), 256'd1);
        send(2'd1, 1'b1, 1'b1, 256'd2);
        cyc();
        chk("max_single", 256'(vector_out), 256'd2);
        send(2'd1, 1'b0, 1'b1, 256'd1);
        cyc();
        chk("max_cleared", 256'(vector_out), 256'd1);

        for (int i = 0; i < 4; i++) begin
            send(2'd0, i == 0, i == 3, splat(32'd1));
            send(2'd2, i == 0, i == 3, splat(32'd100));
        end
        chk("il_c0_valid", 256'(valid_out), 256'd1);
        chk("il_c0_vec", 256'(vector_out), splat(32'd4));
        chk("il_c0_chain", 256'(chainId_out), 256'd0);
        cyc();
        chk("il_c2_vec", 256'(vector_out), splat(32'd400));
        chk("il_c2_chain", 256'(chainId_out), 256'd2);

        send(2'd0, 1'b1, 1'b0, splat(32'hFFFF_FFFF));
        send(2'd0, 1'b0, 1'b1, splat(32'd2));
        cyc();
        chk("wrap_vec", 256'(vector_out), splat(32'd1));

        send(2'd2, 1'b1, 1'b0, splat(32'd5));
        cyc();
        tracing = 1'b0;
        cyc();
        chk("trc_low_valid", 256'(valid_out), 256'd0);
        tracing = 1'b1;
        send(2'd2, 1'b0, 1'b1, splat(32'd1));
        cyc();
        chk("trc_clear_vec", 256'(vector_out), splat(32'd1));

        send(2'd0, 1'b1, 1'b0, splat(32'd5));
        send(2'd0, 1'b0, 1'b0, splat(32'd5));
        rst_n = 1'b0;
        #1;
        chk("mrst_vec", 256'(vector_out), 256'd0);
        chk("mrst_valid", 256'(valid_out), 256'd0);
        cyc();
        chk("mrst_valid_hold", 256'(valid_out), 256'd0);
        rst_n = 1'b1;
        send(2'd0, 1'b0, 1'b1, splat(32'd3));
        cyc();
        chk("mrst_after_vec", 256'(vector_out), splat(32'd3));
        chk("mrst_after_valid", 256'(valid_out), 256'd1);
        send(2'd0, 1'b0, 1'b0, splat(32'd7));
        cyc();
        chk("mrst_fw_pass", 256'(valid_out), 256'd1);

        // chain0 MAX, chain1 PASS, chain2 SUM, chain3 PASS
        config4(8'd2, 8'd0, 8'd1, 8'd0);
        send(2'd1, 1'b0, 1'b0, splat(32'hAB));
        cyc();
        chk("cfg_pass_valid", 256'(valid_out), 256'd1);
        chk("cfg_pass_vec", 256'(vector_out), splat(32'hAB));
        chk("cfg_pass_chain", 256'(chainId_out), 256'd1);
        send(2'd0, 1'b1, 1'b0, splat(32'd5));
        send(2'd0, 1'b0, 1'b1, splat(32'd3));
        cyc();
        chk("cfg_max_vec", 256'(vector_out), splat(32'd5));
        send(2'd2, 1'b1, 1'b0, splat(32'd4));
        send(2'd2, 1'b0, 1'b1, splat(32'd6));
        cyc();
        chk("cfg_sum_vec", 256'(vector_out), splat(32'd10));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
